mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage; consumes the execute-to-memory bus and the data SRAM read response.
- Aligns and sign/zero-extends load data (ld.b/bu/h/hu/w) and selects the load or ALU result.
- Buffers the response when write-back stalls; forwards dest/value to decode for bypass and interlock.
- Uses the standard valid/allowin pipeline handshake.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_stage_load_align.sv | 36 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: load op codes, bus field offsets
// and the stage state encoding.
package mem_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  // es_to_ms_bus field positions
  localparam int ES_PC_LSB       = 0;
  localparam int ES_RESULT_LSB   = 32;
  localparam int ES_DEST_LSB     = 64;
  localparam int ES_GR_WE        = 69;
  localparam int ES_RES_FROM_MEM = 70;
  localparam int ES_ADDR_LSB     = 71;
  localparam int ES_LD_OP_LSB    = 73;

  // ms_to_ws_bus field positions
  localparam int MS_PC_LSB     = 0;
  localparam int MS_RESULT_LSB = 32;
  localparam int MS_DEST_LSB   = 64;
  localparam int MS_GR_WE      = 69;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } ms_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load word and sign/zero-extends it.
// Purely combinational.
module load_align (
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);
  import mem_pkg::*;

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[addr_low];
  // addr_low[0] is deliberately ignored for halfwords; misalignment traps upstream
  assign half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (ld_op)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {24'd0, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for load data, buffers it across write-back
// stalls, aligns it and forwards dest/value back to decode.
module mem_stage #(
  parameter int ES_BUS_W = 76,
  parameter int MS_BUS_W = 70
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ws_allowin,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  input  logic [31:0]         data_sram_rdata,
  input  logic                data_sram_data_ok,
  output logic                ms_to_ws_valid,
  output logic [MS_BUS_W-1:0] ms_to_ws_bus,
  output logic [4:0]          ms_to_ds_dest,
  output logic [31:0]         ms_to_ds_value,
  output logic                ms_value_pending
);
  import mem_pkg::*;

  ms_state_t             state_reg, state_next;
  logic                  ms_valid_reg;
  logic                  rbuf_valid_reg;
  logic [31:0]           rbuf_reg;
  logic [ES_BUS_W-1:0]   bus_reg;

  logic [2:0]  ld_op;
  logic [1:0]  addr_low;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        ms_ready_go;
  logic        accept;
  logic        handoff;
  logic        rbuf_load;
  ms_state_t   accept_state;

  assign ld_op        = bus_reg[ES_LD_OP_LSB +: 3];
  assign addr_low     = bus_reg[ES_ADDR_LSB +: 2];
  assign res_from_mem = bus_reg[ES_RES_FROM_MEM];
  assign gr_we        = bus_reg[ES_GR_WE];
  assign dest         = bus_reg[ES_DEST_LSB +: 5];
  assign alu_result   = bus_reg[ES_RESULT_LSB +: 32];
  assign pc           = bus_reg[ES_PC_LSB +: 32];

  assign ms_ready_go    = (state_reg == READY) || ((state_reg == WAIT) && data_sram_data_ok);
  assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign handoff        = ms_to_ws_valid && ws_allowin;

  always_comb begin
    accept_state = EMPTY;
    if (accept)
      accept_state = es_to_ms_bus[ES_RES_FROM_MEM] ? WAIT : READY;
  end

  // data_ok is only meaningful in WAIT; in EMPTY/READY it is a stray pulse
  always_comb begin
    state_next = state_reg;
    rbuf_load  = 1'b0;
    case (state_reg)
      EMPTY: state_next = accept_state;
      WAIT: begin
        if (data_sram_data_ok) begin
          if (ws_allowin) begin
            state_next = accept_state;
          end else begin
            state_next = READY;
            rbuf_load  = 1'b1;
          end
        end
      end
      READY: if (ws_allowin) state_next = accept_state;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= EMPTY;
      ms_valid_reg   <= 1'b0;
      rbuf_valid_reg <= 1'b0;
      rbuf_reg       <= '0;
      bus_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (ms_allowin)
        ms_valid_reg <= es_to_ms_valid;
      if (accept)
        bus_reg <= es_to_ms_bus;
      if (rbuf_load) begin
        rbuf_valid_reg <= 1'b1;
        rbuf_reg       <= data_sram_rdata;
      end else if (handoff) begin
        rbuf_valid_reg <= 1'b0;
      end
    end
  end

  assign mem_rdata = rbuf_valid_reg ? rbuf_reg : data_sram_rdata;

  load_align u_load_align (
    .ld_op     (ld_op),
    .addr_low  (addr_low),
    .rdata     (mem_rdata),
    .load_data (load_data)
  );

  assign final_result = res_from_mem ? load_data : alu_result;

  assign ms_to_ws_bus     = {gr_we, dest, final_result, pc};
  assign ms_to_ds_dest    = (ms_valid_reg && gr_we) ? dest : 5'd0;
  assign ms_to_ds_value   = (ms_valid_reg && gr_we && ms_ready_go) ? final_result : 32'd0;
  assign ms_value_pending = ms_valid_reg && res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected write-back bus
// values checked at every handoff.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_value;
  logic        ms_value_pending;

  int n_checks = 0;
  int n_errors = 0;
  logic [69:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_rdata   (data_sram_rdata),
    .data_sram_data_ok (data_sram_data_ok),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_dest     (ms_to_ds_dest),
    .ms_to_ds_value    (ms_to_ds_value),
    .ms_value_pending  (ms_value_pending)
  );

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] mk(input logic [2:0] op, input logic [1:0] a,
                                     input logic rfm, input logic we, input logic [4:0] d,
                                     input logic [31:0] res, input logic [31:0] pc);
    return {op, a, rfm, we, d, res, pc};
  endfunction

  // Sample at the falling edge; pop the scoreboard on every handoff
  task automatic neg();
    logic [69:0] e;
    @(negedge clk);
    if (ms_to_ws_valid && ws_allowin) begin
      chk("sb_q_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_handoff", ms_to_ws_bus, e);
        $display("handoff pc=%h dest=%0d value=%h", ms_to_ws_bus[31:0],
                 ms_to_ws_bus[68:64], ms_to_ws_bus[63:32]);
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [1:0] a, input logic [4:0] d,
                         input logic [31:0] pc, input logic [31:0] rd, input logic [31:0] expv);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(op, a, 1'b1, 1'b1, d, 32'h0BAD_0BAD, pc);
    exp_q.push_back({1'b1, d, expv, pc});
    neg(); chk("ld_accept_allowin", ms_allowin, 1'b1); pos();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    neg();
    chk("ld_pending_wait", ms_value_pending, 1'b1);
    chk("ld_wait_no_valid", ms_to_ws_valid, 1'b0);
    chk("ld_fwd_dest", ms_to_ds_dest, d);
    chk("ld_fwd_value_zero", ms_to_ds_value, 32'd0);
    pos();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    neg();
    chk("ld_pending_clear", ms_value_pending, 1'b0);
    chk("ld_fwd_value", ms_to_ds_value, expv);
    pos();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0000_DEAD;
    neg(); chk("ld_drained", ms_to_ws_valid, 1'b0); pos();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    data_sram_data_ok = 1'b0;
    pos(); pos();

    // reset state
    neg();
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ws_bus", ms_to_ws_bus, 70'd0);
    chk("rst_ds_dest", ms_to_ds_dest, 5'd0);
    chk("rst_ds_value", ms_to_ds_value, 32'd0);
    chk("rst_pending", ms_value_pending, 1'b0);
    pos();
    reset = 1'b0;

    // ALU op
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h100);
    exp_q.push_back({1'b1, 5'd5, 32'h1234_5678, 32'h100});
    neg(); chk("alu_accept", ms_allowin, 1'b1); pos();
    es_to_ms_valid = 1'b0;
    neg();
    chk("alu_ws_valid", ms_to_ws_valid, 1'b1);
    chk("alu_ds_dest", ms_to_ds_dest, 5'd5);
    chk("alu_ds_value", ms_to_ds_value, 32'h1234_5678);
    chk("alu_no_pending", ms_value_pending, 1'b0);
    pos();

    // aligned/extended loads
    do_load(3'd1, 2'd3, 5'd7, 32'h104, 32'h80FF_0000, 32'hFFFF_FF80); // ld.b
    do_load(3'd4, 2'd2, 5'd8, 32'h108, 32'hBEEF_1234, 32'h0000_BEEF); // ld.hu
    do_load(3'd3, 2'd2, 5'd8, 32'h10C, 32'hBEEF_1234, 32'hFFFF_BEEF); // ld.h
    do_load(3'd0, 2'd0, 5'd9, 32'h110, 32'hA5A5_5A5A, 32'hA5A5_5A5A); // ld.w

    // load response arrives while write-back stalls
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd2, 2'd0, 1'b1, 1'b1, 5'd9, 32'h77, 32'h300);
    exp_q.push_back({1'b1, 5'd9, 32'h0000_00AA, 32'h300});
    neg(); chk("stall_accept", ms_allowin, 1'b1); pos();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_56AA;
    neg();
    chk("stall_valid", ms_to_ws_valid, 1'b1);
    chk("stall_allowin_0", ms_allowin, 1'b0);
    pos();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0000_DEAD;
    neg();
    chk("stall_allowin_1", ms_allowin, 1'b0);
    chk("stall_buffered_1", ms_to_ws_bus[63:32], 32'h0000_00AA);
    pos();
    data_sram_data_ok = 1'b1;  // stray pulse while holding
    neg();
    chk("stall_allowin_2", ms_allowin, 1'b0);
    chk("stall_buffered_2", ms_to_ws_bus[63:32], 32'h0000_00AA);
    pos();
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    neg(); chk("stall_release_allowin", ms_allowin, 1'b1); pos();
    neg(); chk("stall_drained", ms_to_ws_valid, 1'b0); pos();

    // back-to-back load then ALU op
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 2'd0, 1'b1, 1'b1, 5'd10, 32'h0, 32'h200);
    exp_q.push_back({1'b1, 5'd10, 32'hCAFE_F00D, 32'h200});
    neg(); chk("b2b_accept_ld", ms_allowin, 1'b1); pos();
    es_to_ms_bus   = mk(3'd0, 2'd0, 1'b0, 1'b1, 5'd11, 32'h55, 32'h204);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    exp_q.push_back({1'b1, 5'd11, 32'h55, 32'h204});
    neg(); chk("b2b_accept_alu", ms_allowin, 1'b1); pos();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    neg(); chk("b2b_no_bubble", ms_to_ws_valid, 1'b1); pos();
    neg(); chk("b2b_drained", ms_to_ws_valid, 1'b0); pos();

    // asynchronous reset while waiting for load data
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(3'd0, 2'd0, 1'b1, 1'b1, 5'd12, 32'h0, 32'h400);
    neg(); chk("rw_accept", ms_allowin, 1'b1); pos();
    es_to_ms_valid = 1'b0;
    neg(); chk("rw_pending", ms_value_pending, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rw_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rw_ds_dest", ms_to_ds_dest, 5'd0);
    chk("rw_pending_clr", ms_value_pending, 1'b0);
    chk("rw_allowin", ms_allowin, 1'b1);
    pos(); pos();
    reset = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hFFFF_FFFF;
    neg();
    chk("rw_spurious_valid", ms_to_ws_valid, 1'b0);
    chk("rw_spurious_pending", ms_value_pending, 1'b0);
    chk("rw_spurious_allowin", ms_allowin, 1'b1);
    pos();
    data_sram_data_ok = 1'b0;
    neg(); chk("rw_idle", ms_to_ws_valid, 1'b0); pos();

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
